// File: rtl/mux_n_1_pkg.sv
// Shared encodings for the N:1 stream mux: mode values, output FSM states,
// and the channel-index width helper.
package mux_n_1_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_rr_arb.sv
// Round-robin search: first requesting channel at or after ptr, wrapping mod N.
module mux_n_1_rr_arb #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          any
);

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= N) t = t - N;
    return SW'(t);
  endfunction

  // Scan from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) begin
        grant = wrap_add(ptr, k);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_stream.sv
// N:1 valid/ready stream mux with a one-word registered output stage.
// Define MUX_N_1_STREAM_RR_EN to add the mode port and round-robin arbitration.
//   state    | meaning
//   ST_EMPTY | no word held, y_valid=0
//   ST_FULL  | word held in y/y_sel, y_valid=1
module mux_n_1_stream
  import mux_n_1_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3,
  localparam int SW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW-1:0]   s,
`ifdef MUX_N_1_STREAM_RR_EN
  input  logic            mode,
`endif
  input  logic [N*W-1:0]  d,
  input  logic [N-1:0]    d_valid,
  output logic [N-1:0]    d_ready,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   y_sel,
  output logic            y_valid,
  input  logic            y_ready
);

  state_e          state_q, state_d;
  logic [W-1:0]    y_q, y_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [SW-1:0]   c;
  logic            sel_ok;
  logic            accept;
  logic            xfer;
  logic [W-1:0]    d_sel;
  logic            dv_sel;

`ifdef MUX_N_1_STREAM_RR_EN
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   rr_grant;
  logic            rr_any;
  logic            use_rr;

  mux_n_1_rr_arb #(.N(N), .SW(SW)) u_rr_arb (
    .req   (d_valid),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .any   (rr_any)
  );

  assign use_rr = (mode == MODE_RR);
  assign c      = use_rr ? rr_grant : s;
  assign sel_ok = use_rr ? rr_any : (int'(s) < N);
`else
  assign c      = s;
  assign sel_ok = (int'(s) < N);
`endif

  // rst_n gates accept so no channel sees ready while reset is held.
  assign accept = rst_n & ((state_q == ST_EMPTY) | y_ready);

  always_comb begin
    d_ready = '0;
    d_sel   = '0;
    dv_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (c == SW'(i)) begin
        d_ready[i] = accept & sel_ok;
        d_sel      = d[i*W +: W];
        dv_sel     = d_valid[i];
      end
    end
  end

  assign xfer = accept & sel_ok & dv_sel;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
`ifdef MUX_N_1_STREAM_RR_EN
    ptr_d   = ptr_q;
`endif
    if (xfer) begin
      state_d = ST_FULL;
      y_d     = d_sel;
      sel_d   = c;
`ifdef MUX_N_1_STREAM_RR_EN
      if (use_rr) ptr_d = (c == SW'(N - 1)) ? '0 : c + 1'b1;
`endif
    end else if (state_q == ST_FULL && y_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      sel_q   <= '0;
`ifdef MUX_N_1_STREAM_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
`ifdef MUX_N_1_STREAM_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign y       = y_q;
  assign y_sel   = sel_q;
  assign y_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed bench for mux_n_1_stream (N=8 and N=5 instances); round-robin
// steps run only when MUX_N_1_STREAM_RR_EN is defined.
module tb_mux_n_1_stream;

  logic        clk;
  logic        rst_n;
  logic [2:0]  s;
  logic        mode;
  logic [23:0] d;
  logic [7:0]  dv;
  logic [7:0]  d_ready;
  logic [2:0]  y;
  logic [2:0]  y_sel;
  logic        y_valid;
  logic        yr;

  logic [2:0]  s5;
  logic        mode5;
  logic [14:0] d5;
  logic [4:0]  dv5;
  logic [4:0]  d_ready5;
  logic [2:0]  y5;
  logic [2:0]  y_sel5;
  logic        y_valid5;
  logic        yr5;

  int checks   = 0;
  int failures = 0;

  mux_n_1_stream #(.N(8), .W(3)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
`ifdef MUX_N_1_STREAM_RR_EN
    .mode    (mode),
`endif
    .d       (d),
    .d_valid (dv),
    .d_ready (d_ready),
    .y       (y),
    .y_sel   (y_sel),
    .y_valid (y_valid),
    .y_ready (yr)
  );

  mux_n_1_stream #(.N(5), .W(3)) u_dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s5),
`ifdef MUX_N_1_STREAM_RR_EN
    .mode    (mode5),
`endif
    .d       (d5),
    .d_valid (dv5),
    .d_ready (d_ready5),
    .y       (y5),
    .y_sel   (y_sel5),
    .y_valid (y_valid5),
    .y_ready (yr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [2:0] v);
    d[i*3 +: 3] = v;
  endtask

  initial begin
    rst_n = 1'b0; s = 3'd5; mode = 1'b0; d = '0; dv = 8'h20; yr = 1'b1;
    s5 = '0; mode5 = 1'b0; d5 = '0; dv5 = '0; yr5 = 1'b1;
    #2;
    chk("rst_y_valid", y_valid, 1'b0);
    chk("rst_y", y, 3'd0);
    chk("rst_y_sel", y_sel, 3'd0);
    chk("rst_d_ready", d_ready, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Fixed select, single channel 5 valid, downstream always ready.
    set_d(5, 3'd6);
    #1;
    chk("fix5_ready_pre", d_ready, 8'h20);
    step();
    chk("fix5_y", y, 3'd6);
    chk("fix5_y_sel", y_sel, 3'd5);
    chk("fix5_y_valid", y_valid, 1'b1);
    chk("fix5_ready_full", d_ready, 8'h20);
    dv = 8'h00;
    #1;
    chk("fix5_ready_no_valid", d_ready, 8'h20);
    step();
    chk("drain_y_valid", y_valid, 1'b0);
    chk("drain_y_hold", y, 3'd6);
    chk("drain_sel_hold", y_sel, 3'd5);

    // Stall: load channel 2, then hold with y_ready low for 10 cycles.
    s = 3'd2; dv = 8'h04; set_d(2, 3'd3); yr = 1'b0;
    step();
    chk("stall_load_y", y, 3'd3);
    chk("stall_load_valid", y_valid, 1'b1);
    set_d(2, 3'd5); s = 3'd7;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("stall_d_ready", d_ready, 8'h00);
      step();
      chk("stall_valid", y_valid, 1'b1);
      chk("stall_y", y, 3'd3);
      chk("stall_sel", y_sel, 3'd2);
    end
    s = 3'd2; yr = 1'b1;
    #1;
    chk("unstall_ready", d_ready, 8'h04);
    step();
    chk("unstall_y", y, 3'd5);
    chk("unstall_sel", y_sel, 3'd2);
    chk("unstall_valid", y_valid, 1'b1);
    dv = 8'h00;
    step();
    chk("empty_again", y_valid, 1'b0);

    // N=5 instance: out-of-range select accepts nothing, top channel works.
    s5 = 3'd6; dv5 = 5'h1f; d5[4*3 +: 3] = 3'd7;
    #1;
    chk("n5_oor_ready", d_ready5, 5'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("n5_oor_valid", y_valid5, 1'b0);
    end
    s5 = 3'd4;
    #1;
    chk("n5_s4_ready", d_ready5, 5'h10);
    step();
    chk("n5_s4_y", y5, 3'd7);
    chk("n5_s4_sel", y_sel5, 3'd4);
    chk("n5_s4_valid", y_valid5, 1'b1);

    // Async reset while holding a stalled word.
    s = 3'd1; set_d(1, 3'd2); dv = 8'h02; yr = 1'b0;
    step();
    chk("prerst_y", y, 3'd2);
    chk("prerst_valid", y_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", y_valid, 1'b0);
    chk("async_rst_y", y, 3'd0);
    chk("async_rst_sel", y_sel, 3'd0);
    chk("async_rst_ready", d_ready, 8'h00);
    #1 rst_n = 1'b1;
    yr = 1'b1;
    step();
    chk("post_rst_y", y, 3'd2);
    chk("post_rst_sel", y_sel, 3'd1);
    chk("post_rst_valid", y_valid, 1'b1);

`ifdef MUX_N_1_STREAM_RR_EN
    // Round-robin: all channels valid gives 0..7,0 with no bubbles.
    dv = 8'h00;
    step();
    mode = 1'b1; dv = 8'hff;
    for (int i = 0; i < 8; i++) set_d(i, 3'(i));
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_all_sel", y_sel, 3'(k % 8));
      chk("rr_all_y", y, 3'(k % 8));
      chk("rr_all_valid", y_valid, 1'b1);
    end
    // ptr is 1 here; grant channel 5 to move ptr to 6.
    dv = 8'h20;
    step();
    chk("rr_to6_sel", y_sel, 3'd5);
    dv = 8'h03;
    step();
    chk("rr_wrap_sel0", y_sel, 3'd0);
    step();
    chk("rr_wrap_sel1", y_sel, 3'd1);
    dv = 8'h07;
    step();
    chk("rr_ptr2_sel", y_sel, 3'd2);
    // Fixed-mode transfer in between must leave ptr at 3.
    mode = 1'b0; s = 3'd0; dv = 8'h01;
    step();
    chk("rr_fix_sel", y_sel, 3'd0);
    mode = 1'b1; dv = 8'hff;
    step();
    chk("rr_ptr_kept", y_sel, 3'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
